// File: rtl/pq_buffer_pkg.sv
// pq_buffer_pkg: state encodings and counter helper shared by the ping-pong buffer controller
package pq_buffer_pkg;
  typedef enum logic {W_FILL = 1'b0, W_FULL = 1'b1} wstate_t;
  typedef enum logic {R_IDLE = 1'b0, R_DRAIN = 1'b1} rstate_t;
  function automatic logic cnt_last(input int unsigned cnt, input int unsigned len);
    return cnt == len - 1;
  endfunction
endpackage

// File: rtl/pq_lat_pipe.sv
// pq_lat_pipe: DEPTH-stage delay line carrying {valid, last} to line up with buffer read data
module pq_lat_pipe #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic valid_in,
  input  logic last_in,
  output logic valid_out,
  output logic last_out
);
  logic [1:0] sr [DEPTH];
  // shift the read strobe along; clr drops every read still in flight
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) for (int i = 0; i < DEPTH; i++) sr[i] <= '0;
    else if (clr) for (int i = 0; i < DEPTH; i++) sr[i] <= '0;
    else begin
      sr[0] <= {valid_in, last_in};
      for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
    end
  assign {valid_out, last_out} = sr[DEPTH-1];
endmodule

// File: rtl/pq_buffer_ctrl.sv
// pq_buffer_ctrl: write/read sequencing and bank swap for a two-bank ping-pong buffer
module pq_buffer_ctrl
  import pq_buffer_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int FRAME_LEN  = 16,
  parameter int RD_LAT     = 2,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic                  m_ready,
  output logic                  m_valid,
  output logic                  m_last,
  output logic                  buf_ctrl,
  output logic                  buf_wr_en,
  output logic [ADDR_WIDTH-1:0] buf_wr_addr,
  output logic                  buf_rd_en,
  output logic [ADDR_WIDTH-1:0] buf_rd_addr,
  output logic [CNT_WIDTH-1:0]  frames_done
);
  wstate_t               wstate;
  rstate_t               rstate;
  logic [ADDR_WIDTH-1:0] wcnt, rcnt;
  logic                  w_last, r_last, swap;
  assign s_ready     = wstate == W_FILL && !flush;
  assign buf_wr_en   = s_valid && s_ready;
  assign buf_wr_addr = wcnt;
  assign buf_rd_en   = rstate == R_DRAIN && m_ready && !flush;
  assign buf_rd_addr = rcnt;
  assign w_last      = cnt_last(32'(wcnt), FRAME_LEN);
  assign r_last      = cnt_last(32'(rcnt), FRAME_LEN);
  assign swap        = wstate == W_FULL && rstate == R_IDLE && !flush;
  // write/read counters, both FSMs and the bank swap; flush outranks everything
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wstate      <= W_FILL;
      rstate      <= R_IDLE;
      wcnt        <= '0;
      rcnt        <= '0;
      buf_ctrl    <= 1'b0;
      frames_done <= '0;
    end else if (flush) begin
      wstate <= W_FILL;
      rstate <= R_IDLE;
      wcnt   <= '0;
      rcnt   <= '0;
    end else begin
      if (buf_wr_en) begin
        wcnt <= w_last ? '0 : wcnt + 1'b1;
        if (w_last) wstate <= W_FULL;
      end
      if (buf_rd_en) begin
        rcnt <= r_last ? '0 : rcnt + 1'b1;
        if (r_last) begin
          rstate      <= R_IDLE;
          frames_done <= frames_done + 1'b1;
        end
      end
      if (swap) begin
        buf_ctrl <= ~buf_ctrl;
        wstate   <= W_FILL;
        rstate   <= R_DRAIN;
      end
    end
  pq_lat_pipe #(.DEPTH(RD_LAT)) u_lat (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (flush),
    .valid_in (buf_rd_en),
    .last_in  (buf_rd_en && r_last),
    .valid_out(m_valid),
    .last_out (m_last)
  );
endmodule

// File: tb/tb_pq_buffer_ctrl.sv
// tb_pq_buffer_ctrl: vector table, corner sequences and randomized model check of pq_buffer_ctrl
module tb_pq_buffer_ctrl;
  localparam int AW = 4, FL = 16, RL = 2, CW = 16;
  logic clk = 0, rst_n = 0, flush = 0, s_valid = 0, m_ready = 0;
  logic s_ready, m_valid, m_last, buf_ctrl, buf_wr_en, buf_rd_en;
  logic [AW-1:0] buf_wr_addr, buf_rd_addr;
  logic [CW-1:0] frames_done;
  int checks = 0, errors = 0;

  pq_buffer_ctrl #(.ADDR_WIDTH(AW), .FRAME_LEN(FL), .RD_LAT(RL), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .s_valid(s_valid), .s_ready(s_ready),
    .m_ready(m_ready), .m_valid(m_valid), .m_last(m_last), .buf_ctrl(buf_ctrl),
    .buf_wr_en(buf_wr_en), .buf_wr_addr(buf_wr_addr), .buf_rd_en(buf_rd_en),
    .buf_rd_addr(buf_rd_addr), .frames_done(frames_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic sv, mr;
    logic e_srdy, e_wr;
    logic [3:0] e_waddr;
    logic e_ctrl, e_rd;
    logic [3:0] e_raddr;
    logic e_mv;
  } vec_t;
  vec_t tbl [20];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic sv, input logic mr, input logic fl);
    s_valid = sv; m_ready = mr; flush = fl;
    @(negedge clk);
  endtask

  task automatic adv;
    @(posedge clk); #1;
  endtask

  task automatic do_reset;
    s_valid = 0; m_ready = 0; flush = 0; rst_n = 0;
    @(posedge clk); #1;
    rst_n = 1;
  endtask

  int wfill, rleft, bank, done, lastf, cyc;
  bit hv [4096];
  bit hl [4096];
  bit pend [2][FL];

  task automatic model_reset;
    wfill = 0; rleft = 0; bank = 0; done = 0; cyc = 0; lastf = -1;
    for (int b = 0; b < 2; b++) for (int a = 0; a < FL; a++) pend[b][a] = 0;
  endtask

  task automatic model_step;
    bit e_srdy, e_wr, e_rd, sw;
    int c;
    e_srdy = wfill < FL && !flush;
    e_wr = s_valid && e_srdy;
    e_rd = rleft > 0 && m_ready && !flush;
    c = cyc - RL;
    chk("s_ready", 32'(s_ready), 32'(e_srdy));
    chk("wr_en", 32'(buf_wr_en), 32'(e_wr));
    chk("wr_addr", 32'(buf_wr_addr), wfill % FL);
    chk("rd_en", 32'(buf_rd_en), 32'(e_rd));
    chk("rd_addr", 32'(buf_rd_addr), rleft > 0 ? FL - rleft : 0);
    chk("ctrl", 32'(buf_ctrl), bank);
    chk("m_valid", 32'(m_valid), 32'(c >= 0 && c > lastf && hv[c]));
    chk("m_last", 32'(m_last), 32'(c >= 0 && c > lastf && hl[c]));
    chk("frames_done", 32'(frames_done), done % (1 << CW));
    if (buf_wr_en) begin
      chk("overwrite", 32'(pend[buf_ctrl][buf_wr_addr]), 0);
      pend[buf_ctrl][buf_wr_addr] = 1;
    end
    if (buf_rd_en) begin
      chk("read_unwritten", 32'(pend[!buf_ctrl][buf_rd_addr]), 1);
      pend[!buf_ctrl][buf_rd_addr] = 0;
    end
    hv[cyc] = e_rd;
    hl[cyc] = e_rd && rleft == 1;
    sw = wfill == FL && rleft == 0 && !flush;
    if (flush) begin
      wfill = 0; rleft = 0; lastf = cyc;
      for (int b = 0; b < 2; b++) for (int a = 0; a < FL; a++) pend[b][a] = 0;
    end else begin
      if (e_wr) wfill++;
      if (e_rd) begin
        rleft--;
        if (rleft == 0) done++;
      end
      if (sw) begin
        bank ^= 1; wfill = 0; rleft = FL;
      end
    end
    cyc++;
  endtask

  initial begin
    int nrd, nwr, nmv, nml, mr_pct;
    bit seen;
    for (int i = 0; i < 16; i++) tbl[i] = '{1'b1, 1'b1, 1'b1, 1'b1, 4'(i), 1'b0, 1'b0, 4'd0, 1'b0};
    tbl[16] = '{1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0};
    for (int i = 17; i < 20; i++) tbl[i] = '{1'b1, 1'b1, 1'b1, 1'b1, 4'(i-17), 1'b1, 1'b1, 4'(i-17), 1'(i == 19)};

    @(negedge clk);
    chk("rst_s_ready", 32'(s_ready), 1);
    chk("rst_wr_en", 32'(buf_wr_en), 0);
    chk("rst_rd_en", 32'(buf_rd_en), 0);
    chk("rst_addrs", 32'({buf_wr_addr, buf_rd_addr}), 0);
    chk("rst_ctrl", 32'(buf_ctrl), 0);
    chk("rst_m", 32'({m_valid, m_last}), 0);
    chk("rst_frames", 32'(frames_done), 0);
    do_reset;

    for (int i = 0; i < 20; i++) begin
      drive(tbl[i].sv, tbl[i].mr, 1'b0);
      chk($sformatf("tbl%0d_s_ready", i), 32'(s_ready), 32'(tbl[i].e_srdy));
      chk($sformatf("tbl%0d_wr_en", i), 32'(buf_wr_en), 32'(tbl[i].e_wr));
      chk($sformatf("tbl%0d_wr_addr", i), 32'(buf_wr_addr), 32'(tbl[i].e_waddr));
      chk($sformatf("tbl%0d_ctrl", i), 32'(buf_ctrl), 32'(tbl[i].e_ctrl));
      chk($sformatf("tbl%0d_rd_en", i), 32'(buf_rd_en), 32'(tbl[i].e_rd));
      chk($sformatf("tbl%0d_rd_addr", i), 32'(buf_rd_addr), 32'(tbl[i].e_raddr));
      chk($sformatf("tbl%0d_m_valid", i), 32'(m_valid), 32'(tbl[i].e_mv));
      adv;
    end
    for (int t = 20; t <= 34; t++) begin
      drive(1'(t <= 32), 1'b1, 1'b0);
      if (t == 32) begin
        chk("lastboth_rd", 32'({buf_rd_en, buf_rd_addr}), 32'h1f);
        chk("lastboth_wr", 32'({buf_wr_en, buf_wr_addr}), 32'h1f);
      end
      if (t == 33) begin
        chk("swapcyc_s_ready", 32'(s_ready), 0);
        chk("swapcyc_rd_en", 32'(buf_rd_en), 0);
        chk("swapcyc_frames", 32'(frames_done), 1);
        chk("swapcyc_ctrl", 32'(buf_ctrl), 1);
      end
      if (t == 34) begin
        chk("mlast_out", 32'({m_valid, m_last}), 3);
        chk("swapped_ctrl", 32'(buf_ctrl), 0);
      end
      adv;
    end

    do_reset;
    for (int k = 0; k < 17; k++) begin drive(1'b1, 1'b1, 1'b0); adv; end
    for (int k = 0; k < 16; k++) begin drive(1'b1, 1'b0, 1'b0); adv; end
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, 1'b0, 1'b0);
      chk("bp_s_ready", 32'(s_ready), 0);
      chk("bp_wr_en", 32'(buf_wr_en), 0);
      adv;
    end
    nrd = 0; seen = 0;
    for (int k = 0; k < 40 && !seen; k++) begin
      drive(1'b1, 1'b1, 1'b0);
      if (buf_ctrl == 1'b0) seen = 1;
      else begin
        nrd += int'(buf_rd_en);
        adv;
      end
    end
    chk("bp_swap_seen", 32'(seen), 1);
    chk("bp_reads", nrd, FL);
    chk("bp_frames", 32'(frames_done), 1);
    adv;

    do_reset;
    for (int k = 0; k < 17; k++) begin drive(1'b1, 1'b1, 1'b0); adv; end
    for (int k = 0; k < 4; k++) begin drive(1'b1, 1'b0, 1'b0); adv; end
    for (int k = 0; k < 3; k++) begin drive(1'b1, 1'b1, 1'b0); adv; end
    drive(1'b1, 1'b1, 1'b1);
    chk("fl_addrs", 32'({buf_wr_addr, buf_rd_addr}), 32'h73);
    chk("fl_s_ready", 32'(s_ready), 0);
    chk("fl_enables", 32'({buf_wr_en, buf_rd_en}), 0);
    chk("fl_m_valid_before", 32'(m_valid), 1);
    adv;
    drive(1'b0, 1'b1, 1'b0);
    chk("post_fl_addrs", 32'({buf_wr_addr, buf_rd_addr}), 0);
    chk("post_fl_m_valid", 32'(m_valid), 0);
    chk("post_fl_rd_en", 32'(buf_rd_en), 0);
    chk("post_fl_s_ready", 32'(s_ready), 1);
    chk("post_fl_ctrl", 32'(buf_ctrl), 1);
    chk("post_fl_frames", 32'(frames_done), 0);
    adv;
    nwr = 0; nrd = 0; nmv = 0; nml = 0;
    for (int k = 0; k < 40; k++) begin
      drive(1'(k < 16), 1'b1, 1'b0);
      nwr += int'(buf_wr_en); nrd += int'(buf_rd_en);
      nmv += int'(m_valid); nml += int'(m_last);
      adv;
    end
    chk("refill_writes", nwr, FL);
    chk("refill_reads", nrd, FL);
    chk("refill_mvalid", nmv, FL);
    chk("refill_mlast", nml, 1);
    chk("refill_frames", 32'(frames_done), 1);
    chk("refill_ctrl", 32'(buf_ctrl), 0);

    do_reset;
    model_reset;
    for (int n = 0; n < 3000; n++) begin
      if (n == 1500) begin
        do_reset;
        model_reset;
      end
      mr_pct = (n / 500) % 3 == 0 ? 95 : (n / 500) % 3 == 1 ? 50 : 20;
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 99) < mr_pct), 1'($urandom_range(0, 199) == 0));
      model_step;
      adv;
    end

    s_valid = 0; m_ready = 1; flush = 0;
    #3 rst_n = 0;
    #1;
    chk("arst_ctrl", 32'(buf_ctrl), 0);
    chk("arst_addrs", 32'({buf_wr_addr, buf_rd_addr}), 0);
    chk("arst_enables", 32'({buf_wr_en, buf_rd_en}), 0);
    chk("arst_m", 32'({m_valid, m_last}), 0);
    chk("arst_frames", 32'(frames_done), 0);
    adv;
    rst_n = 1;
    adv;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pq_buffer_ctrl.md
Name: pq_buffer_ctrl

Overview:
- Sequencing controller for the two-bank ping-pong buffer.
- Accepts a producer stream through a valid/ready handshake and generates the buffer's write/read enables, addresses and bank-select `ctrl`.
- Decides when the banks swap, and emits an output-valid/last strobe aligned to the buffer's read data.
- Sits between the upstream producer, the buffer and the downstream consumer; data words pass straight to the buffer and do not go through this block.

Parameters:
- ADDR_WIDTH, 4: buffer address width.
- FRAME_LEN, 16: words per frame; legal range 2..2^ADDR_WIDTH.
- RD_LAT, 2: cycles from buf_rd_en to valid buffer dout; must be ≥1.
- CNT_WIDTH, 16: width of the completed-frame counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- flush  in  1  synchronous abort of both frames in progress
- s_valid  in  1  producer word valid
- s_ready  out  1  controller can accept a word this cycle
- m_ready  in  1  consumer can take a read request this cycle
- m_valid  out  1  buffer dout valid this cycle
- m_last  out  1  the m_valid word is the last word of its frame
- buf_ctrl  out  1  bank select (1: bank1 written / bank2 read; 0: the reverse)
- buf_wr_en  out  1  buffer write enable
- buf_wr_addr  out  ADDR_WIDTH  buffer write address
- buf_rd_en  out  1  buffer read enable
- buf_rd_addr  out  ADDR_WIDTH  buffer read address
- frames_done  out  CNT_WIDTH  count of frames fully read out; wraps modulo 2^CNT_WIDTH

Behaviour:
- Reset values: buf_ctrl=0; wcnt=rcnt=0; wstate=W_FILL; rstate=R_IDLE; latency pipeline cleared; frames_done=0.
- Consequently buf_wr_en=0, buf_rd_en=0, both addresses 0, m_valid=m_last=0.
- s_ready is combinational: (wstate==W_FILL) && !flush. It reads 1 during reset; the producer must hold s_valid=0 while rst_n is low.
- Write FSM:
  - W_FILL: buf_wr_en = s_valid && s_ready; buf_wr_addr = wcnt.
  - On each accepted word wcnt increments. The word with wcnt==FRAME_LEN-1 sets wcnt=0 and moves to W_FULL.
  - W_FULL: s_ready=0, buf_wr_en=0. Leaves only through a swap.
- Read FSM:
  - R_DRAIN: buf_rd_en = m_ready; buf_rd_addr = rcnt.
  - Each issued read increments rcnt. The read with rcnt==FRAME_LEN-1 sets rcnt=0, increments frames_done and moves to R_IDLE.
  - R_IDLE: buf_rd_en=0.
- Swap:
  - Occurs when wstate==W_FULL && rstate==R_IDLE && !flush.
  - At the next edge: buf_ctrl toggles, wstate becomes W_FILL, rstate becomes R_DRAIN.
  - The swap cycle has no write and no read by construction.
  - Reads still in flight complete correctly because the buffer delays its output select by RD_LAT.
- Output alignment: a shift register of depth RD_LAT carries {rd_en, last-flag}. m_valid/m_last equal the buf_rd_en / (rcnt==FRAME_LEN-1) values from exactly RD_LAT cycles earlier.
- No read backpressure after issue: the consumer must accept every m_valid word. m_ready throttles issue only.
- Throughput: steady state gives a 1-cycle write bubble per frame. Writing frame N+1 overlaps reading frame N.
- Producer faster than consumer: the write side sits in W_FULL with s_ready=0 until the read side drains. No overwrite is possible.
- Simultaneous events:
  - The last write and last read in the same cycle: both states update, and the swap occurs on the following cycle.
  - flush has priority over all accepts and swaps.
- flush: wcnt=rcnt=0, wstate=W_FILL, rstate=R_IDLE, latency pipeline cleared so that m_valid=0 from the next cycle. buf_ctrl and frames_done are kept. While flush=1: s_ready=0, buf_wr_en=0, buf_rd_en=0.
- Mid-operation reset returns every register immediately to its reset value. Partial frames are discarded.

Decomposition:
- Shared package pq_buffer_pkg holds:
  - write-state encoding: W_FILL=1'b0, W_FULL=1'b1;
  - read-state encoding: R_IDLE=1'b0, R_DRAIN=1'b1;
  - a function for counter last-value compare.
- One natural sub-module, pq_lat_pipe: a parameterised RD_LAT-deep shift register with asynchronous reset and synchronous clear, carrying {valid, last}.
- Write FSM, read FSM and swap logic stay in the top module.

Test Plan:
- Reset, then s_valid=1 for 16 cycles with m_ready=1 (FRAME_LEN=16):
  - writes go to addresses 0..15 with buf_ctrl=0;
  - buf_ctrl=1 one cycle after the last write;
  - reads of addresses 0..15 follow;
  - m_valid runs 16 cycles starting RD_LAT after the first rd_en, with m_last on the 16th;
  - frames_done=1.
- Continuous streaming of 4 frames with m_ready=1: s_ready low exactly 1 cycle per frame boundary, buf_ctrl toggles 4 times, frames_done=4, and no address is written twice before it is read.
- m_ready=0 after frame 1 is swapped in: frame 2 fills, wstate stays W_FULL, s_ready=0 indefinitely, no buf_wr_en. Raising m_ready drains frame 1, then the swap occurs.
- m_ready toggling 1/0 every cycle: rd_addr advances only on rd_en, and m_valid shows the same 1/0 pattern delayed by RD_LAT.
- flush asserted mid-write (wcnt=7) and mid-read (rcnt=3): next cycle wcnt=rcnt=0, m_valid=0, buf_ctrl unchanged, frames_done unchanged. A following full frame is then processed normally.
- rst_n pulsed low mid-frame: all outputs return to reset values asynchronously, without waiting for a clock edge.
